// File: rtl/rgb_fade_sequencer_if.sv
// ---------------------------------------------------------------------------
// rgb_fade_sequencer_if
// Bundles the control inputs and colour outputs of rgb_fade_sequencer.
//   en          : 1 = run, 0 = freeze every register and hold the outputs
//   mode        : 00 fade-cycle, 01 step-cycle, 10 freeze, 11 blank
//   R/G/B_time_out : per-channel duty words (DW bits) for the PWM generators
//   color_idx   : current palette index ("from" colour while fading)
//   fading      : high while a cross-fade is in progress
//   wrap_pulse  : one-cycle pulse after the palette index wraps to 0
// Modports: master = controller side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface rgb_fade_sequencer_if #(
   parameter int DW = 8
);
   logic          en;
   logic [1:0]    mode;
   logic [DW-1:0] R_time_out;
   logic [DW-1:0] G_time_out;
   logic [DW-1:0] B_time_out;
   logic [2:0]    color_idx;
   logic          fading;
   logic          wrap_pulse;

   modport master (
      output en, mode,
      input  R_time_out, G_time_out, B_time_out, color_idx, fading, wrap_pulse
   );

   modport slave (
      input  en, mode,
      output R_time_out, G_time_out, B_time_out, color_idx, fading, wrap_pulse
   );
endinterface

// File: rtl/rgb_fade_sequencer.sv
// ---------------------------------------------------------------------------
// rgb_fade_sequencer
// Steps through the first NUM_COLORS entries of a fixed 8-colour palette on
// the divided clock, either hard-switching (step-cycle) or linearly
// cross-fading (fade-cycle) between neighbouring colours, and drives one
// duty word per channel for the downstream PWM generators.
// Ports:
//   clk_div : sequencer clock
//   rst     : asynchronous, active-high reset (outputs go to black at once)
//   bus     : rgb_fade_sequencer_if.slave (en, mode in; duty words, index,
//             fading and wrap_pulse out)
// Duty words are a combinational function of the state registers.
// ---------------------------------------------------------------------------
module rgb_fade_sequencer #(
   parameter int DW         = 8,
   parameter int NUM_COLORS = 8,
   parameter int FADE_STEPS = 16,
   parameter int HOLD_TICKS = 32
) (
   input logic                 clk_div,
   input logic                 rst,
   rgb_fade_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      BLANK = 2'd0,
      HOLD  = 2'd1,
      FADE  = 2'd2
   } state_t;

   localparam logic [2:0]           LAST_IDX = 3'(NUM_COLORS - 1);
   localparam logic [8:0]           STEP_END = 9'(FADE_STEPS);
   localparam logic [15:0]          HOLD_END = 16'(HOLD_TICKS - 1);
   localparam logic signed [DW+9:0] STEPS_S  = (DW+10)'(FADE_STEPS);

   state_t      state, state_nx;
   logic [2:0]  idx, idx_nx, nxt_idx;
   logic [8:0]  step, step_nx;
   logic [15:0] hold_cnt, hold_nx;
   logic        wrap_q, wrap_nx;
   logic        advance;
   logic [23:0] from_rgb, to_rgb;
   logic [DW-1:0] r_out, g_out, b_out;

   // 8-bit palette as {R,G,B}
   function automatic logic [23:0] pal8(input logic [2:0] i);
      case (i)
         3'd0:    pal8 = {8'd255, 8'd0,   8'd0  };
         3'd1:    pal8 = {8'd255, 8'd97,  8'd0  };
         3'd2:    pal8 = {8'd255, 8'd255, 8'd0  };
         3'd3:    pal8 = {8'd0,   8'd255, 8'd0  };
         3'd4:    pal8 = {8'd0,   8'd0,   8'd255};
         3'd5:    pal8 = {8'd8,   8'd46,  8'd84 };
         3'd6:    pal8 = {8'd160, 8'd32,  8'd240};
         default: pal8 = {8'd255, 8'd255, 8'd255};
      endcase
   endfunction

   // Scale an 8-bit palette channel up to the duty word width
   function automatic logic [DW-1:0] widen(input logic [7:0] c);
      widen = DW'(c) << (DW - 8);
   endfunction

   // from + (to-from)*stp/FADE_STEPS; signed divide truncates toward zero so
   // falling channels approach the target symmetrically with rising ones
   function automatic logic [DW-1:0] lerp(input logic [DW-1:0] from,
                                          input logic [DW-1:0] to,
                                          input logic [8:0]    stp);
      logic signed [DW+9:0] f, t, prod, q;
      f    = $signed({10'd0, from});
      t    = $signed({10'd0, to});
      prod = (t - f) * $signed({{(DW+1){1'b0}}, stp});
      q    = prod / STEPS_S;
      lerp = DW'(f + q);
   endfunction

   assign nxt_idx = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      step_nx  = step;
      hold_nx  = hold_cnt;
      wrap_nx  = 1'b0;
      advance  = 1'b0;
      if (bus.mode == 2'b11) begin
         state_nx = BLANK;
         idx_nx   = 3'd0;
         step_nx  = 9'd0;
         hold_nx  = 16'd0;
      end else begin
         case (state)
            BLANK: begin
               state_nx = HOLD;
               idx_nx   = 3'd0;
               step_nx  = 9'd0;
               hold_nx  = 16'd0;
            end
            HOLD: begin
               if (hold_cnt == HOLD_END) begin
                  case (bus.mode)
                     2'b00: begin
                        state_nx = FADE;
                        step_nx  = 9'd1;
                        hold_nx  = 16'd0;
                     end
                     2'b01:   advance = 1'b1;
                     default: ;  // freeze: counter stays saturated
                  endcase
               end else begin
                  hold_nx = hold_cnt + 16'd1;
               end
            end
            FADE: begin
               case (bus.mode)
                  2'b00: begin
                     if (step == STEP_END) advance = 1'b1;
                     else                  step_nx = step + 9'd1;
                  end
                  2'b01:   advance = 1'b1;  // abort straight to next colour
                  default: ;                // freeze on the intermediate step
               endcase
            end
            default: state_nx = BLANK;
         endcase
      end
      if (advance) begin
         state_nx = HOLD;
         idx_nx   = nxt_idx;
         step_nx  = 9'd0;
         hold_nx  = 16'd0;
         wrap_nx  = (idx == LAST_IDX);
      end
   end

   always_ff @(posedge clk_div or posedge rst) begin
      if (rst) begin
         state    <= BLANK;
         idx      <= 3'd0;
         step     <= 9'd0;
         hold_cnt <= 16'd0;
         wrap_q   <= 1'b0;
      end else if (bus.en) begin
         state    <= state_nx;
         idx      <= idx_nx;
         step     <= step_nx;
         hold_cnt <= hold_nx;
         wrap_q   <= wrap_nx;
      end else begin
         // paused: state held, but the wrap pulse must not stretch
         wrap_q   <= 1'b0;
      end
   end

   assign from_rgb = pal8(idx);
   assign to_rgb   = pal8(nxt_idx);

   always_comb begin
      r_out = '0;
      g_out = '0;
      b_out = '0;
      case (state)
         HOLD: begin
            r_out = widen(from_rgb[23:16]);
            g_out = widen(from_rgb[15:8]);
            b_out = widen(from_rgb[7:0]);
         end
         FADE: begin
            r_out = lerp(widen(from_rgb[23:16]), widen(to_rgb[23:16]), step);
            g_out = lerp(widen(from_rgb[15:8]),  widen(to_rgb[15:8]),  step);
            b_out = lerp(widen(from_rgb[7:0]),   widen(to_rgb[7:0]),   step);
         end
         default: ;
      endcase
   end

   assign bus.R_time_out = r_out;
   assign bus.G_time_out = g_out;
   assign bus.B_time_out = b_out;
   assign bus.color_idx  = idx;
   assign bus.fading     = (state == FADE);
   assign bus.wrap_pulse = wrap_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rgb_fade_sequencer
// Two sequencers (8 and 7 palette entries, FADE_STEPS=4, HOLD_TICKS=2) run
// against a behavioural model; directed scenarios also pin literal colours.
// ---------------------------------------------------------------------------
module tb_rgb_fade_sequencer;

   localparam int FS = 4;
   localparam int HT = 2;

   logic clk_div = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk_div = ~clk_div;

   rgb_fade_sequencer_if #(.DW(8)) bus8 ();
   rgb_fade_sequencer_if #(.DW(8)) bus7 ();

   rgb_fade_sequencer #(.DW(8), .NUM_COLORS(8), .FADE_STEPS(FS), .HOLD_TICKS(HT))
      u_dut8 (.clk_div(clk_div), .rst(rst), .bus(bus8));
   rgb_fade_sequencer #(.DW(8), .NUM_COLORS(7), .FADE_STEPS(FS), .HOLD_TICKS(HT))
      u_dut7 (.clk_div(clk_div), .rst(rst), .bus(bus7));

   // ---------------- behavioural model ----------------
   // ph: 0 = dark, 1 = showing a colour, 2 = blending towards the next one
   typedef struct {
      int ph;
      int idx;
      int stp;
      int hc;
      int wrap;
   } mdl_t;

   int PR[8] = '{255, 255, 255, 0,   0,   8,  160, 255};
   int PG[8] = '{0,   97,  255, 255, 0,   46, 32,  255};
   int PB[8] = '{0,   0,   0,   0,   255, 84, 240, 255};

   mdl_t m8, m7;

   function automatic mdl_t mdl_next(mdl_t m, logic e, logic [1:0] md, int n);
      mdl_t r;
      bit   go;
      r      = m;
      r.wrap = 0;
      go     = 0;
      if (!e) return r;
      if (md == 2'b11) begin
         r = '{default: 0};
         return r;
      end
      if (m.ph == 0) begin
         r.ph = 1; r.idx = 0; r.stp = 0; r.hc = 0;
      end else if (m.ph == 1) begin
         if (m.hc < HT - 1)   r.hc = m.hc + 1;
         else if (md == 2'b00) begin r.ph = 2; r.stp = 1; r.hc = 0; end
         else if (md == 2'b01) go = 1;
      end else begin
         if (md == 2'b01) go = 1;
         else if (md == 2'b00) begin
            if (m.stp == FS) go = 1;
            else             r.stp = m.stp + 1;
         end
      end
      if (go) begin
         r.ph = 1; r.idx = (m.idx + 1) % n; r.stp = 0; r.hc = 0;
         r.wrap = (r.idx == 0) ? 1 : 0;
      end
      return r;
   endfunction

   function automatic int mdl_col(mdl_t m, int ch, int n);
      int a, b, t;
      t = (m.idx + 1) % n;
      case (ch)
         0:       begin a = PR[m.idx]; b = PR[t]; end
         1:       begin a = PG[m.idx]; b = PG[t]; end
         default: begin a = PB[m.idx]; b = PB[t]; end
      endcase
      if (m.ph == 0) return 0;
      if (m.ph == 1) return a;
      return a + ((b - a) * m.stp) / FS;
   endfunction

   always @(posedge clk_div or posedge rst) begin
      if (rst) begin
         m8 <= '{default: 0};
         m7 <= '{default: 0};
      end else begin
         m8 <= mdl_next(m8, bus8.en, bus8.mode, 8);
         m7 <= mdl_next(m7, bus7.en, bus7.mode, 7);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // compare both DUTs against the model on every falling edge
   always @(negedge clk_div) begin
      check("m8.R",    int'(bus8.R_time_out), mdl_col(m8, 0, 8));
      check("m8.G",    int'(bus8.G_time_out), mdl_col(m8, 1, 8));
      check("m8.B",    int'(bus8.B_time_out), mdl_col(m8, 2, 8));
      check("m8.idx",  int'(bus8.color_idx),  m8.idx);
      check("m8.fade", int'(bus8.fading),     (m8.ph == 2) ? 1 : 0);
      check("m8.wrap", int'(bus8.wrap_pulse), m8.wrap);
      check("m7.R",    int'(bus7.R_time_out), mdl_col(m7, 0, 7));
      check("m7.G",    int'(bus7.G_time_out), mdl_col(m7, 1, 7));
      check("m7.B",    int'(bus7.B_time_out), mdl_col(m7, 2, 7));
      check("m7.idx",  int'(bus7.color_idx),  m7.idx);
      check("m7.fade", int'(bus7.fading),     (m7.ph == 2) ? 1 : 0);
      check("m7.wrap", int'(bus7.wrap_pulse), m7.wrap);
   end

   // ---------------- directed literal checks ----------------
   task automatic lit8(input string name, input int r, input int g, input int b,
                       input int idx, input int fad, input int wrp);
      check({name, ".R"},    int'(bus8.R_time_out), r);
      check({name, ".G"},    int'(bus8.G_time_out), g);
      check({name, ".B"},    int'(bus8.B_time_out), b);
      check({name, ".idx"},  int'(bus8.color_idx),  idx);
      check({name, ".fade"}, int'(bus8.fading),     fad);
      check({name, ".wrap"}, int'(bus8.wrap_pulse), wrp);
   endtask

   task automatic lit7(input string name, input int r, input int g, input int b,
                       input int idx, input int fad, input int wrp);
      check({name, ".R"},    int'(bus7.R_time_out), r);
      check({name, ".G"},    int'(bus7.G_time_out), g);
      check({name, ".B"},    int'(bus7.B_time_out), b);
      check({name, ".idx"},  int'(bus7.color_idx),  idx);
      check({name, ".fade"}, int'(bus7.fading),     fad);
      check({name, ".wrap"}, int'(bus7.wrap_pulse), wrp);
   endtask

   task automatic cyc();
      @(posedge clk_div);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      bus8.en   = 1'b0;
      bus8.mode = 2'b00;
      bus7.en   = 1'b0;
      bus7.mode = 2'b00;
      #12;
      lit8("reset", 0, 0, 0, 0, 0, 0);
      #10;
      rst = 1'b0;

      // step-cycle through the whole palette and wrap
      bus8.en   = 1'b1;
      bus8.mode = 2'b01;
      cyc(); lit8("step_c0", 255, 0, 0, 0, 0, 0);
      cyc(); lit8("step_c0b", 255, 0, 0, 0, 0, 0);
      cyc(); lit8("step_c1", 255, 97, 0, 1, 0, 0);
      repeat (12) cyc();
      lit8("step_c7", 255, 255, 255, 7, 0, 0);
      cyc(); cyc();
      lit8("step_wrap", 255, 0, 0, 0, 0, 1);
      cyc(); lit8("step_wrap_end", 255, 0, 0, 0, 0, 0);

      // blank, then rising fade 0 -> 1
      bus8.mode = 2'b11;
      cyc(); lit8("blank", 0, 0, 0, 0, 0, 0);
      bus8.mode = 2'b00;
      cyc(); lit8("fade_hold0", 255, 0, 0, 0, 0, 0);
      cyc(); lit8("fade_hold1", 255, 0, 0, 0, 0, 0);
      cyc(); lit8("fade_s1", 255, 24, 0, 0, 1, 0);
      cyc(); lit8("fade_s2", 255, 48, 0, 0, 1, 0);
      cyc(); lit8("fade_s3", 255, 72, 0, 0, 1, 0);
      cyc(); lit8("fade_s4", 255, 97, 0, 0, 1, 0);
      cyc(); lit8("fade_done", 255, 97, 0, 1, 0, 0);
      cyc(); lit8("fade_done_b", 255, 97, 0, 1, 0, 0);

      // freeze mid-fade, then resume
      bus8.mode = 2'b11;
      cyc();
      bus8.mode = 2'b00;
      cyc(); cyc(); cyc(); cyc();
      lit8("frz_at48", 255, 48, 0, 0, 1, 0);
      bus8.mode = 2'b10;
      for (int i = 0; i < 10; i++) begin
         cyc(); lit8("frz_hold", 255, 48, 0, 0, 1, 0);
      end
      bus8.mode = 2'b00;
      cyc(); lit8("frz_resume3", 255, 72, 0, 0, 1, 0);
      cyc(); lit8("frz_resume4", 255, 97, 0, 0, 1, 0);

      // abort a fade 1 -> 2
      cyc(); cyc(); cyc();
      lit8("abort_s1", 255, 136, 0, 1, 1, 0);
      bus8.mode = 2'b01;
      cyc(); lit8("abort", 255, 255, 0, 2, 0, 0);

      // pause during falling fade 2 -> 3
      bus8.mode = 2'b00;
      cyc(); cyc();
      lit8("pause_s1", 192, 255, 0, 2, 1, 0);
      cyc(); lit8("pause_s2", 128, 255, 0, 2, 1, 0);
      bus8.en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc(); lit8("pause_hold", 128, 255, 0, 2, 1, 0);
      end
      bus8.en = 1'b1;
      cyc(); lit8("pause_s3", 64, 255, 0, 2, 1, 0);
      cyc(); lit8("pause_s4", 0, 255, 0, 2, 1, 0);

      // asynchronous reset in the middle of fade 3 -> 4
      cyc(); cyc(); cyc();
      lit8("rst_pre", 0, 192, 63, 3, 1, 0);
      #2 rst = 1'b1;
      #1 lit8("rst_async", 0, 0, 0, 0, 0, 0);
      bus8.en = 1'b0;
      cyc();
      rst = 1'b0;
      repeat (3) cyc();
      lit8("rst_idle", 0, 0, 0, 0, 0, 0);

      // 7-colour palette: falling fade from idx 6 back to 0
      bus7.en   = 1'b1;
      bus7.mode = 2'b01;
      repeat (13) cyc();
      lit7("n7_c6", 160, 32, 240, 6, 0, 0);
      bus7.mode = 2'b00;
      cyc(); cyc();
      lit7("n7_s1", 183, 24, 180, 6, 1, 0);
      cyc(); lit7("n7_s2", 207, 16, 120, 6, 1, 0);
      cyc(); lit7("n7_s3", 231, 8, 60, 6, 1, 0);
      cyc(); lit7("n7_s4", 255, 0, 0, 6, 1, 0);
      cyc(); lit7("n7_wrap", 255, 0, 0, 0, 0, 1);
      cyc(); lit7("n7_wrap_end", 255, 0, 0, 0, 0, 0);
      repeat (2) cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
